// File: rtl/crossbar_pkg.sv
// Shared types and constants for the parametrised master/slave crossbar.
package crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_RESP = 2'd2
  } slave_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/xbar_arbiter.sv
// Per-slave arbiter: round-robin after the last winner, or fixed lowest-index priority.
module xbar_arbiter
  import crossbar_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] rr_last_q, rr_last_d;

  // Scan from the lowest priority down so the highest-priority candidate is the last to stick.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (MODE == ARB_FIXED) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[k]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'(k);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (req[(int'(rr_last_q) + k) % N]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'((int'(rr_last_q) + k) % N);
        end
      end
    end
  end

  assign rr_last_d = advance ? gnt_idx : rr_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= IDX_W'(N - 1);
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/crossbar_arb.sv
// MASTERS x SLAVES crossbar: one request cell per master, one arbiter and
// single-outstanding FSM per slave, decode errors and response timeout.
module crossbar_arb
  import crossbar_pkg::*;
#(
  parameter int MASTERS  = 4,
  parameter int SLAVES   = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_RR,
  parameter int TIMEOUT  = 255,
  localparam int SEL_W   = $clog2(SLAVES),
  localparam int SA_W    = ADDR_W - SEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MASTERS-1:0]         m_req,
  input  logic [MASTERS-1:0]         m_cmd,
  input  logic [MASTERS*ADDR_W-1:0]  m_addr,
  input  logic [MASTERS*DATA_W-1:0]  m_wdata,
  output logic [MASTERS-1:0]         m_gnt,
  output logic [MASTERS-1:0]         m_ack,
  output logic [MASTERS-1:0]         m_resp,
  output logic [MASTERS*DATA_W-1:0]  m_rdata,
  output logic [MASTERS-1:0]         m_err,
  output logic [SLAVES-1:0]          s_req,
  output logic [SLAVES-1:0]          s_cmd,
  output logic [SLAVES*SA_W-1:0]     s_addr,
  output logic [SLAVES*DATA_W-1:0]   s_wdata,
  input  logic [SLAVES-1:0]          s_ack,
  input  logic [SLAVES-1:0]          s_resp,
  input  logic [SLAVES*DATA_W-1:0]   s_rdata
);

  localparam int MIDX_W = $clog2(MASTERS);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [MASTERS-1:0]        busy_q, busy_d, valid_q, valid_d, cmd_q, cmd_d;
  logic [SEL_W-1:0]          sel_q   [MASTERS];
  logic [SEL_W-1:0]          sel_d   [MASTERS];
  logic [SA_W-1:0]           addr_q  [MASTERS];
  logic [SA_W-1:0]           addr_d  [MASTERS];
  logic [DATA_W-1:0]         wdata_q [MASTERS];
  logic [DATA_W-1:0]         wdata_d [MASTERS];
  logic [MASTERS-1:0]        m_ack_q, m_ack_d, m_resp_q, m_resp_d, m_err_q, m_err_d;
  logic [MASTERS*DATA_W-1:0] m_rdata_q, m_rdata_d;

  slave_state_e              state_q [SLAVES];
  slave_state_e              state_d [SLAVES];
  logic [MIDX_W-1:0]         owner_q [SLAVES];
  logic [MIDX_W-1:0]         owner_d [SLAVES];
  logic [TMO_W-1:0]          tmo_q   [SLAVES];
  logic [TMO_W-1:0]          tmo_d   [SLAVES];
  logic [SLAVES-1:0]         s_req_q, s_req_d, s_cmd_q, s_cmd_d;
  logic [SLAVES*SA_W-1:0]    s_addr_q, s_addr_d;
  logic [SLAVES*DATA_W-1:0]  s_wdata_q, s_wdata_d;

  logic [SEL_W-1:0]          m_sel     [MASTERS];
  logic [MASTERS-1:0]        m_dec_err;
  logic [MASTERS-1:0]        arb_req   [SLAVES];
  logic [MIDX_W-1:0]         arb_idx   [SLAVES];
  logic [SLAVES-1:0]         arb_valid, arb_adv, tmo_hit;

  assign m_gnt = m_req & ~busy_q;

  genvar gi, gj;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_dec
      assign m_sel[gi]     = m_addr[gi*ADDR_W + ADDR_W - 1 -: SEL_W];
      assign m_dec_err[gi] = 32'(m_sel[gi]) >= SLAVES;
    end
    for (gi = 0; gi < SLAVES; gi++) begin : g_slv
      for (gj = 0; gj < MASTERS; gj++) begin : g_req
        assign arb_req[gi][gj] = valid_q[gj] && (sel_q[gj] == SEL_W'(gi));
      end
      assign tmo_hit[gi] = (TIMEOUT != 0) && (tmo_q[gi] == TMO_W'(TIMEOUT - 1));
      xbar_arbiter #(.N(MASTERS), .MODE(ARB_MODE)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req[gi]),
        .advance   (arb_adv[gi]),
        .gnt_idx   (arb_idx[gi]),
        .gnt_valid (arb_valid[gi])
      );
    end
  endgenerate

  always_comb begin
    busy_d = busy_q;  valid_d = valid_q;  cmd_d = cmd_q;
    sel_d  = sel_q;   addr_d  = addr_q;   wdata_d = wdata_q;
    m_ack_d = '0;  m_resp_d = '0;  m_err_d = '0;  m_rdata_d = m_rdata_q;
    state_d = state_q;  owner_d = owner_q;  tmo_d = tmo_q;
    s_req_d = '0;  s_cmd_d = s_cmd_q;  s_addr_d = s_addr_q;  s_wdata_d = s_wdata_q;
    arb_adv = '0;

    // Undecoded addresses complete immediately and never occupy a cell.
    for (int i = 0; i < MASTERS; i++) begin
      if (m_gnt[i]) begin
        if (m_dec_err[i]) begin
          m_ack_d[i] = 1'b1;
          m_err_d[i] = 1'b1;
          if (!m_cmd[i]) begin
            m_resp_d[i] = 1'b1;
            m_rdata_d[i*DATA_W +: DATA_W] = '0;
          end
        end else begin
          busy_d[i]  = 1'b1;
          valid_d[i] = 1'b1;
          cmd_d[i]   = m_cmd[i];
          sel_d[i]   = m_sel[i];
          addr_d[i]  = m_addr[i*ADDR_W +: SA_W];
          wdata_d[i] = m_wdata[i*DATA_W +: DATA_W];
        end
      end
    end

    for (int s = 0; s < SLAVES; s++) begin
      case (state_q[s])
        IDLE: begin
          if (arb_valid[s]) begin
            arb_adv[s]  = 1'b1;
            s_req_d[s]  = 1'b1;
            s_cmd_d[s]  = cmd_q[arb_idx[s]];
            s_addr_d[s*SA_W +: SA_W]      = addr_q[arb_idx[s]];
            s_wdata_d[s*DATA_W +: DATA_W] = wdata_q[arb_idx[s]];
            valid_d[arb_idx[s]] = 1'b0;
            owner_d[s] = arb_idx[s];
            tmo_d[s]   = '0;
            state_d[s] = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (s_ack[s]) begin
            m_ack_d[owner_q[s]] = 1'b1;
            tmo_d[s] = '0;
            if (s_cmd_q[s]) begin
              busy_d[owner_q[s]] = 1'b0;
              state_d[s] = IDLE;
            end else begin
              state_d[s] = WAIT_RESP;
            end
          end else if (tmo_hit[s]) begin
            m_ack_d[owner_q[s]] = 1'b1;
            m_err_d[owner_q[s]] = 1'b1;
            if (!s_cmd_q[s]) begin
              m_resp_d[owner_q[s]] = 1'b1;
              m_rdata_d[int'(owner_q[s])*DATA_W +: DATA_W] = '0;
            end
            busy_d[owner_q[s]] = 1'b0;
            state_d[s] = IDLE;
          end else begin
            tmo_d[s] = tmo_q[s] + TMO_W'(1);
          end
        end
        WAIT_RESP: begin
          if (s_resp[s] || tmo_hit[s]) begin
            m_resp_d[owner_q[s]] = 1'b1;
            m_err_d[owner_q[s]]  = !s_resp[s];
            m_rdata_d[int'(owner_q[s])*DATA_W +: DATA_W] =
              s_resp[s] ? s_rdata[s*DATA_W +: DATA_W] : '0;
            busy_d[owner_q[s]] = 1'b0;
            state_d[s] = IDLE;
          end else begin
            tmo_d[s] = tmo_q[s] + TMO_W'(1);
          end
        end
        default: state_d[s] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;  valid_q <= '0;  cmd_q <= '0;
      for (int i = 0; i < MASTERS; i++) begin
        sel_q[i]   <= '0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
      m_ack_q <= '0;  m_resp_q <= '0;  m_err_q <= '0;  m_rdata_q <= '0;
      for (int s = 0; s < SLAVES; s++) begin
        state_q[s] <= IDLE;
        owner_q[s] <= '0;
        tmo_q[s]   <= '0;
      end
      s_req_q <= '0;  s_cmd_q <= '0;  s_addr_q <= '0;  s_wdata_q <= '0;
    end else begin
      busy_q <= busy_d;  valid_q <= valid_d;  cmd_q <= cmd_d;
      sel_q  <= sel_d;   addr_q  <= addr_d;   wdata_q <= wdata_d;
      m_ack_q <= m_ack_d;  m_resp_q <= m_resp_d;  m_err_q <= m_err_d;  m_rdata_q <= m_rdata_d;
      state_q <= state_d;  owner_q <= owner_d;  tmo_q <= tmo_d;
      s_req_q <= s_req_d;  s_cmd_q <= s_cmd_d;  s_addr_q <= s_addr_d;  s_wdata_q <= s_wdata_d;
    end
  end

  assign m_ack   = m_ack_q;
  assign m_resp  = m_resp_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_req   = s_req_q;
  assign s_cmd   = s_cmd_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule
